montgomery_reduce_54: RTL

//  Pipelined Montgomery reduction for 54-bit RNS limbs: out = T * 2^-72 mod q.

---
 rtl/montgomery_reduce_54_if.sv | 23 ++
 rtl/montgomery_reduce_54.sv | 108 ++++++++++
 2 files changed

// File: rtl/montgomery_reduce_54_if.sv
// Operand/result bundle for montgomery_reduce_54: early low digit, full product,
// per-op modulus and the registered result with its protocol flag.
interface montgomery_reduce_54_if;
  logic         low_valid;
  logic [23:0]  t_low;
  logic [53:0]  q;
  logic [23:0]  qinv_neg;
  logic         in_valid;
  logic [107:0] t;
  logic         out_valid;
  logic [53:0]  result;
  logic         proto_err;

  modport master (
    output low_valid, t_low, q, qinv_neg, in_valid, t,
    input  out_valid, result, proto_err
  );

  modport slave (
    input  low_valid, t_low, q, qinv_neg, in_valid, t,
    output out_valid, result, proto_err
  );
endinterface

// File: rtl/montgomery_reduce_54.sv
// Pipelined Montgomery reduction, R = 2^72, three 24-bit digits, latency 6.
// q and qinv_neg travel with each op so the modulus may change every cycle.
module montgomery_reduce_54 (
  input  logic                   clk,
  input  logic                   rst,
  montgomery_reduce_54_if.slave  bus
);

  logic [23:0]  r_m0, r_m1, r_m2;
  logic [23:0]  r_qi0, r_qi1, r_qi2, r_qi3;
  logic [53:0]  r_q0, r_q1, r_q2, r_q3, r_q4, r_q5;
  logic [84:0]  r_s1, r_s1b;
  logic [60:0]  r_s2, r_s2b;
  logic [54:0]  r_s3;
  logic         r_v1, r_v2, r_v3, r_v4, r_v5;
  logic         r_lv_d;
  logic         r_out_valid;
  logic         r_proto_err;
  logic [53:0]  r_result;

  logic [23:0]  w_m0, w_m1, w_m2;
  logic [77:0]  w_mq0, w_mq1, w_mq2;
  logic [108:0] w_sum1;
  logic [85:0]  w_sum2;
  logic [78:0]  w_sum3;
  logic [54:0]  w_diff;
  logic         w_ge;
  logic [53:0]  w_res;
  logic         w_unused;

  // 24-bit products truncate naturally to mod 2^24
  assign w_m0   = bus.t_low * bus.qinv_neg;
  assign w_mq0  = r_m0 * r_q0;
  assign w_sum1 = {1'b0, bus.t} + {31'd0, w_mq0};

  assign w_m1   = r_s1[23:0] * r_qi1;
  assign w_mq1  = r_m1 * r_q2;
  assign w_sum2 = {1'b0, r_s1b} + {8'd0, w_mq1};

  assign w_m2   = r_s2[23:0] * r_qi3;
  assign w_mq2  = r_m2 * r_q4;
  assign w_sum3 = {18'd0, r_s2b} + {1'b0, w_mq2};

  assign w_diff = r_s3 - {1'b0, r_q5};
  assign w_ge   = (r_s3 >= {1'b0, r_q5});
  assign w_res  = w_ge ? w_diff[53:0] : r_s3[53:0];

  // Low digits of each sum are zero by construction; top bits cannot be set.
  assign w_unused = ^{w_sum1[23:0], w_sum2[85], w_sum2[23:0], w_sum3[23:0], w_diff[54]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m0 <= '0; r_m1 <= '0; r_m2 <= '0;
      r_qi0 <= '0; r_qi1 <= '0; r_qi2 <= '0; r_qi3 <= '0;
      r_q0 <= '0; r_q1 <= '0; r_q2 <= '0; r_q3 <= '0; r_q4 <= '0; r_q5 <= '0;
      r_s1 <= '0; r_s1b <= '0; r_s2 <= '0; r_s2b <= '0; r_s3 <= '0;
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0; r_v5 <= 1'b0;
      r_lv_d      <= 1'b0;
      r_out_valid <= 1'b0;
      r_proto_err <= 1'b0;
      r_result    <= '0;
    end else begin
      // Early digit stage holds its values so a protocol error reuses stale ones
      if (bus.low_valid) begin
        r_m0  <= w_m0;
        r_q0  <= bus.q;
        r_qi0 <= bus.qinv_neg;
      end
      r_lv_d <= bus.low_valid;
      if (bus.in_valid && !r_lv_d)
        r_proto_err <= 1'b1;

      r_s1  <= w_sum1[108:24];
      r_q1  <= r_q0;
      r_qi1 <= r_qi0;
      r_v1  <= bus.in_valid;

      r_m1  <= w_m1;
      r_s1b <= r_s1;
      r_q2  <= r_q1;
      r_qi2 <= r_qi1;
      r_v2  <= r_v1;

      r_s2  <= w_sum2[84:24];
      r_q3  <= r_q2;
      r_qi3 <= r_qi2;
      r_v3  <= r_v2;

      r_m2  <= w_m2;
      r_s2b <= r_s2;
      r_q4  <= r_q3;
      r_v4  <= r_v3;

      r_s3  <= w_sum3[78:24];
      r_q5  <= r_q4;
      r_v5  <= r_v4;

      r_out_valid <= r_v5;
      if (r_v5)
        r_result <= w_res;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.proto_err = r_proto_err;

endmodule
